// File: rtl/sqrt16_seq_ctrl.sv
// Sequential 16-bit integer square root (restoring, one root bit per cycle).
// A single CLA_16bits instance is reused every iteration as the trial subtractor.

module CLA_16bits (
   input  logic [15:0] A_i,
   input  logic [15:0] B_i,
   input  logic        Ci_i,
   output logic [15:0] S_o,
   output logic        Co_o
);
   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [3:0]  w_gg;
   logic [3:0]  w_gp;
   logic [4:0]  w_gc;

   assign w_g = A_i & B_i;
   assign w_p = A_i ^ B_i;

   // 4-bit group generate/propagate
   always_comb begin
      w_gg = '0;
      w_gp = '0;
      for (int k = 0; k < 4; k++) begin
         w_gp[k] = &w_p[4*k +: 4];
         w_gg[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | ((&w_p[4*k+2 +: 2]) & w_g[4*k+1])
                 | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
      end
   end

   assign w_gc[0] = Ci_i;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & Ci_i);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | ((&w_gp[1:0]) & Ci_i);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | ((&w_gp[2:1]) & w_gg[0])
                  | ((&w_gp[2:0]) & Ci_i);
   assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | ((&w_gp[3:2]) & w_gg[1])
                  | ((&w_gp[3:1]) & w_gg[0]) | ((&w_gp) & Ci_i);

   // Sum bits from each group's lookahead carry-in
   always_comb begin
      logic v_c;
      v_c = 1'b0;
      S_o = '0;
      for (int k = 0; k < 4; k++) begin
         v_c = w_gc[k];
         for (int j = 0; j < 4; j++) begin
            S_o[4*k+j] = w_p[4*k+j] ^ v_c;
            v_c        = w_g[4*k+j] | (w_p[4*k+j] & v_c);
         end
      end
   end

   assign Co_o = w_gc[4];
endmodule

module sqrt16_seq_ctrl (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [15:0] X_i,
   output logic [7:0]  root_o,
   output logic [8:0]  rem_o,
   output logic        busy_o,
   output logic        done_o
);
   localparam int unsigned XW = 16;
   localparam int unsigned QW = 8;
   localparam int unsigned RW = 9;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [XW-1:0] r_xr, w_xr_nxt;
   logic [QW-1:0] r_q, w_q_nxt, w_root_nxt;
   logic [RW-1:0] r_r, w_r_nxt, w_rem_nxt;
   logic          w_busy_nxt, w_done_nxt;

   logic [10:0]   w_rp;
   logic [8:0]    w_t;
   logic [15:0]   w_sum;
   logic          w_co;
   logic [QW-1:0] w_q_iter;
   logic [RW-1:0] w_r_iter;
   logic          w_unused;

   // Trial subtraction R' - T; carry-out set means the trial succeeded
   assign w_rp = {r_r, r_xr[XW-1 -: 2]};
   assign w_t  = {r_q[6:0], 2'b01};

   CLA_16bits u_cla (
      .A_i  ({5'b0, w_rp}),
      .B_i  (~{7'b0, w_t}),
      .Ci_i (1'b1),
      .S_o  (w_sum),
      .Co_o (w_co)
   );

   assign w_q_iter = {r_q[6:0], w_co};
   assign w_r_iter = w_co ? w_sum[8:0] : w_rp[8:0];
   assign w_unused = ^{w_sum[15:9], r_q[7]};

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_xr_nxt    = r_xr;
      w_q_nxt     = r_q;
      w_r_nxt     = r_r;
      w_root_nxt  = root_o;
      w_rem_nxt   = rem_o;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_ITER;
               w_xr_nxt    = X_i;
               w_q_nxt     = '0;
               w_r_nxt     = '0;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_ITER: begin
            w_busy_nxt = 1'b1;
            w_xr_nxt   = r_xr << 2;
            w_q_nxt    = w_q_iter;
            w_r_nxt    = w_r_iter;
            if (r_cnt == CW'(7)) begin
               w_state_nxt = ST_DONE;
               w_root_nxt  = w_q_iter;
               w_rem_nxt   = w_r_iter;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_xr    <= '0;
         r_q     <= '0;
         r_r     <= '0;
         root_o  <= '0;
         rem_o   <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_xr    <= w_xr_nxt;
         r_q     <= w_q_nxt;
         r_r     <= w_r_nxt;
         root_o  <= w_root_nxt;
         rem_o   <= w_rem_nxt;
         busy_o  <= w_busy_nxt;
         done_o  <= w_done_nxt;
      end
   end
endmodule
